// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and instruction field positions for alu_seq_issue
package alu_seq_pkg;
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_LSH = 3'd3;
   localparam logic [2:0] OP_RSH = 3'd4;
   localparam logic [2:0] OP_AND = 3'd5;
   localparam logic [2:0] OP_OR  = 3'd6;
   localparam logic [2:0] OP_XOR = 3'd7;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   localparam int OP_MSB      = 15;
   localparam int OP_LSB      = 13;
   localparam int RD_MSB      = 12;
   localparam int RD_LSB      = 11;
   localparam int RS1_MSB     = 10;
   localparam int RS1_LSB     = 9;
   localparam int IMM_SEL_BIT = 8;
   localparam int IMM_MSB     = 7;
   localparam int IMM_LSB     = 0;
   localparam int RS2_MSB     = 1;
   localparam int RS2_LSB     = 0;
endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4x8 register file, two read ports, second write port under ALU_SEQ_MULHI_WB_EN
module alu_seq_regfile
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [1:0]        rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic              we,
   input  logic [1:0]        waddr,
   input  logic [DATA_W-1:0] wdata
`ifdef ALU_SEQ_MULHI_WB_EN
   ,
   input  logic              we2,
   input  logic [1:0]        waddr2,
   input  logic [DATA_W-1:0] wdata2
`endif
);
   logic [3:0][DATA_W-1:0] regs;
   assign ra_data = regs[ra_addr];
   assign rb_data = regs[rb_addr];
   // write ports; the two addresses never collide since waddr2 is waddr+1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) regs <= '0;
      else begin
         if (we) regs[waddr] <= wdata;
`ifdef ALU_SEQ_MULHI_WB_EN
         if (we2) regs[waddr2] <= wdata2;
`endif
      end
   end
endmodule

// File: rtl/alu_seq_issue.sv
// alu_seq_issue: issue/sequencer front end for the 8-bit ALU; ALU_SEQ_MULHI_WB_EN adds MUL high-byte writeback
module alu_seq_issue
   import alu_seq_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   output logic [2:0]         alu_opcode,
   input  logic [DATA_W-1:0]  alu_y,
   input  logic               alu_carry,
   input  logic [DATA_W-1:0]  alu_mul_hi,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [DATA_W-1:0]  res_data,
   output logic               res_carry,
   output logic [DATA_W-1:0]  res_mul_hi,
   output logic [1:0]         res_rd,
   output logic               busy
);
   state_t            state;
   logic [1:0]        rd_q;
   logic [DATA_W-1:0] rf_a;
   logic [DATA_W-1:0] rf_b;
   logic              is_mul;
   logic              is_logic;
   assign is_mul   = alu_opcode == OP_MUL;
   assign is_logic = alu_opcode == OP_AND || alu_opcode == OP_OR || alu_opcode == OP_XOR;
   alu_seq_regfile #(.DATA_W(DATA_W)) u_rf (
      .clk     (clk),
      .rst     (rst),
      .ra_addr (in_instr[RS1_MSB:RS1_LSB]),
      .ra_data (rf_a),
      .rb_addr (in_instr[RS2_MSB:RS2_LSB]),
      .rb_data (rf_b),
      .we      (state == EXEC),
      .waddr   (rd_q),
      .wdata   (alu_y)
`ifdef ALU_SEQ_MULHI_WB_EN
      ,
      .we2     (state == EXEC && is_mul),
      .waddr2  (rd_q + 2'd1),
      .wdata2  (alu_mul_hi)
`endif
   );
   // issue FSM: latch operands in IDLE, capture ALU outputs in EXEC, hold result in RESP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         res_valid  <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         rd_q       <= '0;
         res_data   <= '0;
         res_carry  <= 1'b0;
         res_mul_hi <= '0;
         res_rd     <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  alu_a      <= rf_a;
                  alu_b      <= in_instr[IMM_SEL_BIT] ? in_instr[IMM_MSB:IMM_LSB] : rf_b;
                  alu_opcode <= in_instr[OP_MSB:OP_LSB];
                  rd_q       <= in_instr[RD_MSB:RD_LSB];
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               res_data   <= alu_y;
               res_carry  <= is_logic ? 1'b0 : alu_carry;
               res_mul_hi <= is_mul ? alu_mul_hi : '0;
               res_rd     <= rd_q;
               res_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq_issue.sv
// tb_alu_seq_issue: directed and random checks of alu_seq_issue against an arithmetic register-file model
module tb_alu_seq_issue;
   import alu_seq_pkg::*;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic [7:0]  alu_a, alu_b, alu_y, alu_mul_hi;
   logic [2:0]  alu_opcode;
   logic        alu_carry;
   logic        res_valid, res_ready, res_carry, busy;
   logic [7:0]  res_data, res_mul_hi;
   logic [1:0]  res_rd;
   logic [15:0] prod;
   int          n_vec = 0;
   int          n_err = 0;
   int          m[4];
   alu_seq_issue dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_opcode (alu_opcode),
      .alu_y      (alu_y),
      .alu_carry  (alu_carry),
      .alu_mul_hi (alu_mul_hi),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_carry  (res_carry),
      .res_mul_hi (res_mul_hi),
      .res_rd     (res_rd),
      .busy       (busy)
   );
   always #5 clk = ~clk;
   // combinational ALU; the product high byte is driven for every opcode
   always_comb begin
      prod       = {8'h00, alu_a} * {8'h00, alu_b};
      alu_mul_hi = prod[15:8];
      alu_carry  = 1'b0;
      alu_y      = 8'h00;
      case (alu_opcode)
         OP_ADD: {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
         OP_SUB: {alu_carry, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
         OP_MUL: alu_y = prod[7:0];
         OP_LSH: {alu_carry, alu_y} = {alu_a, 1'b0};
         OP_RSH: {alu_y, alu_carry} = {1'b0, alu_a};
         OP_AND: alu_y = alu_a & alu_b;
         OP_OR:  alu_y = alu_a | alu_b;
         default: alu_y = alu_a ^ alu_b;
      endcase
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_alu"}, {alu_a, alu_b, alu_opcode}, 0);
      check({tag, "_res"}, {res_data, res_mul_hi, res_carry, res_rd}, 0);
   endtask
   task automatic issue(input int op, input int rd, input int rs1, input int sel, input int opnd, input int hold);
      int a, b, s, ey, ec, eh, n;
      a  = m[rs1];
      b  = sel != 0 ? opnd % 256 : m[opnd % 4];
      eh = 0;
      ec = 0;
      case (op)
         0: begin s = a + b; ey = s % 256; ec = s > 255 ? 1 : 0; end
         1: begin ey = (a - b + 256) % 256; ec = a < b ? 1 : 0; end
         2: begin s = a * b; ey = s % 256; eh = s / 256; end
         3: begin ey = (a * 2) % 256; ec = a >= 128 ? 1 : 0; end
         4: begin ey = a / 2; ec = a % 2; end
         5: ey = a & b;
         6: ey = a | b;
         default: ey = a ^ b;
      endcase
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", in_ready, 1);
      if (!in_ready) return;
      in_instr = {op[2:0], rd[1:0], rs1[1:0], sel[0], opnd[7:0]};
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("accept_in_ready", in_ready, 0);
      check("accept_busy", busy, 1);
      check("alu_a", alu_a, a);
      check("alu_b", alu_b, b);
      check("alu_opcode", alu_opcode, op);
      check("early_res_valid", res_valid, 0);
      @(posedge clk); #1;
      check("res_valid", res_valid, 1);
      for (int i = 0; i <= hold; i++) begin
         check("res_data", res_data, ey);
         check("res_carry", res_carry, ec);
         check("res_mul_hi", res_mul_hi, eh);
         check("res_rd", res_rd, rd);
         check("resp_in_ready", in_ready, 0);
         if (i < hold) begin
            @(posedge clk); #1;
            check("held_res_valid", res_valid, 1);
         end
      end
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk); #1;
      check("done_res_valid", res_valid, 0);
      check("done_in_ready", in_ready, 1);
      check("done_busy", busy, 0);
      @(negedge clk);
      res_ready = 1'b0;
      in_valid  = 1'b0;
      m[rd] = ey;
`ifdef ALU_SEQ_MULHI_WB_EN
      if (op == 2) m[(rd + 1) % 4] = eh;
`endif
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int r3_before;
      rst       = 1'b1;
      in_valid  = 1'b0;
      res_ready = 1'b0;
      in_instr  = '0;
      for (int i = 0; i < 4; i++) m[i] = 0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_in_ready", in_ready, 1);
      issue(0, 1, 0, 1, 8'h05, 0);
      check("load_data", res_data, 8'h05);
      check("load_carry", res_carry, 0);
      check("load_rd", res_rd, 1);
      issue(6, 1, 1, 1, 0, 0);
      check("load_r1", res_data, 8'h05);
      issue(0, 1, 0, 1, 8'hF0, 0);
      issue(0, 2, 1, 1, 8'h20, 0);
      check("ovf_data", res_data, 8'h10);
      check("ovf_carry", res_carry, 1);
      issue(6, 2, 2, 1, 0, 0);
      check("ovf_r2", res_data, 8'h10);
      issue(0, 1, 0, 1, 8'h03, 0);
      issue(0, 2, 0, 1, 8'h05, 0);
      issue(1, 3, 1, 0, 8'hFE, 0);
      check("borrow_data", res_data, 8'hFE);
      check("borrow_carry", res_carry, 1);
      issue(1, 3, 2, 0, 8'h01, 0);
      check("noborrow_data", res_data, 8'h02);
      check("noborrow_carry", res_carry, 0);
      issue(0, 3, 0, 1, 8'h55, 0);
      issue(0, 1, 0, 1, 8'h10, 0);
      issue(2, 2, 1, 1, 8'h20, 0);
      check("mul_lo", res_data, 8'h00);
      check("mul_hi", res_mul_hi, 8'h02);
      issue(6, 3, 3, 1, 0, 0);
`ifdef ALU_SEQ_MULHI_WB_EN
      check("mul_r3", res_data, 8'h02);
`else
      check("mul_r3", res_data, 8'h55);
`endif
      issue(7, 0, 2, 1, 8'h3C, 5);
      issue(4, 1, 0, 1, 8'h00, 0);
      @(negedge clk);
      in_instr = {OP_ADD, 2'd1, 2'd0, 1'b1, 8'h7F};
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("pre_reset_busy", busy, 1);
      rst = 1'b1;
      #1;
      check_reset_outputs("midop");
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) m[i] = 0;
      @(negedge clk);
      rst = 1'b0;
      issue(6, 1, 1, 1, 0, 0);
      check("post_reset_r1", res_data, 0);
      for (int k = 0; k < 200; k++)
         issue($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 3));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
